mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised MEM stage plus MEM/WB pipeline register for the pipelined RISC-V core, replacing the word-only, single-cycle memory stage. It adds RV32I byte/halfword/word loads and stores with sign/zero extension, misalignment detection, configurable memory latency with a stall handshake to the hazard unit, and a WB flush. Internal data memory is a DEPTH_WORDS x XLEN byte-lane array.

Parameters:
XLEN, 32, data/address width (32 only in this revision)
DEPTH_WORDS, 1024, data memory depth in words (power of two)
MEM_LATENCY, 0, extra wait cycles per load/store (0 = single-cycle access)
REG_AW, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
RegWriteM  in  1  register write enable from EX/MEM
MemWriteM  in  1  store request
MemReadM  in  1  load request
ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4 (passed through)
Funct3M  in  3  load/store size/sign encoding
RDM  in  REG_AW  destination register
PCPlus4M  in  XLEN  PC+4
WriteDataM  in  XLEN  store data (rs2)
ALUResultM  in  XLEN  effective address / ALU result
FlushW  in  1  load a bubble into MEM/WB this edge
StallM  out  1  access in progress; upstream holds M inputs and stalls
RegWriteW, ResultSrcW(2), RDW(REG_AW), PCPlus4W, ALUResultW, ReadDataW(XLEN)  out  registered MEM/WB outputs
MisalignW  out  1  registered misaligned/illegal-access flag

Behaviour:
- Reset (rst=0, async): all W outputs 0, FSM IDLE, counter 0, all memory words 0; pending access discarded; StallM=0.
- Word index = ALUResultM[log2(DEPTH_WORDS)+1:2]; higher bits ignored (address wraps mod memory size). Lane = ALUResultM[1:0].
- Stores: 000 SB (byte lane), 001 SH (lanes 1:0 or 3:2), 010 SW; other bytes unchanged. Loads: 000 LB, 001 LH sign-extend; 100 LBU, 101 LHU zero-extend; 010 LW.
- Bad access: halfword with addr[0]=1, word with addr[1:0]!=0, or undefined Funct3M on a load/store -> no memory write, ReadDataW=0, MisalignW=1, RegWriteW=0; completes with no stall.
- MemWriteM and MemReadM both 1: treated as store; ReadDataW=0.
- Load data is the pre-write memory contents; memory write commits only at the completion edge.
- Latency FSM (only when MEM_LATENCY=L>0 and a valid aligned access is present):
  IDLE: access present -> StallM=1, go BUSY, cnt<=1.
  BUSY: cnt<L -> StallM=1, cnt++; cnt==L -> StallM=0, access completes at this edge, go IDLE, cnt<=0.
  L stalled cycles, completion in cycle L (L+1 cycles total). Back-to-back accesses restart from IDLE next cycle. L=0: StallM constantly 0, access completes in the cycle presented.
- MEM/WB register: on completion (or any non-memory cycle) loads M values, ReadDataW = extended load data. During stalled cycles it loads a bubble (RegWriteW=0, MisalignW=0, other fields 0).
- FlushW=1: MEM/WB loads a bubble, overriding normal load; does not abort or delay the memory access or FSM; a store completing that edge still commits.
- Non-memory instructions (MemReadM=MemWriteM=0): pass through with 1-cycle latency, ReadDataW=0, never stall.

Test Plan:
- L=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> ReadDataW=0xDEADBEEF one edge later; StallM never 1.
- L=0: SB 0x000000A5 @0x13, then LB @0x13 -> 0xFFFFFFA5; LBU @0x13 -> 0x000000A5; LW @0x10 -> 0xA5ADBEEF; SH 0x1234 @0x12 then LHU @0x12 -> 0x00001234.
- LH @0x11 with RegWriteM=1 -> MisalignW=1, RegWriteW=0, ReadDataW=0, no stall; LW @0x10 afterwards unchanged.
- L=3: LW @0x10 held stable -> StallM=1 for exactly 3 cycles, RegWriteW=0 in those cycles, then RegWriteW=1, ReadDataW=stored word after the 4th edge.
- L=2: SW 0x55 @0x20 with FlushW=1 at completion edge -> W outputs all 0; subsequent LW @0x20 returns 0x00000055.
- L=3: SW 0x77 @0x30, deassert rst in 2nd BUSY cycle -> StallM=0 and W outputs 0 immediately; after release LW @0x30 returns 0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage with byte-lane data memory, optional access latency and MEM/WB register.
// Sub-word loads are extended here so the writeback mux sees a full XLEN word.
module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [REG_AW-1:0] RDM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic              FlushW,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RDW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic              MisalignW
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LATENCY);

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_extend = {{(XLEN-16){h[15]}}, h};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wd);
    store_merge = old;
    case (f3)
      3'b000: store_merge[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (lane[1]) store_merge[31:16] = wd[15:0];
        else         store_merge[15:0]  = wd[15:0];
      end
      3'b010:  store_merge = wd;
      default: store_merge = old;
    endcase
  endfunction

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        result_src_q, result_src_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic [XLEN-1:0]   read_data_q, read_data_d;
  logic              misalign_q, misalign_d;

  logic              mem_op, is_load, f3_ok, align_ok, bad, acc_valid;
  logic              stall_c, complete, wr_en, load_w;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  word_idx;
  logic [XLEN-1:0]   rd_word, wr_word;

  // Access classification: a store wins when both requests are raised.
  always_comb begin
    mem_op   = MemWriteM | MemReadM;
    is_load  = MemReadM & ~MemWriteM;
    lane     = ALUResultM[1:0];
    word_idx = ALUResultM[IDX_W+1:2];
    case (Funct3M)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
    case (Funct3M[1:0])
      2'b01:   align_ok = ~lane[0];
      2'b10:   align_ok = (lane == 2'b00);
      default: align_ok = 1'b1;
    endcase
    bad       = mem_op & ~(f3_ok & align_ok);
    acc_valid = mem_op & ~bad;
    rd_word   = mem_q[word_idx];
    wr_word   = store_merge(Funct3M, lane, rd_word, WriteDataM);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    complete = 1'b0;
    if (MEM_LATENCY == 0) begin
      complete = acc_valid;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_valid) begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
        BUSY: begin
          if (cnt_q != LAT_C) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            complete = acc_valid;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    wr_en = complete & MemWriteM;
  end

  // MEM/WB next values: bubble while stalled or flushed, otherwise the M fields.
  always_comb begin
    load_w       = ~stall_c & ~FlushW;
    reg_write_d  = load_w & RegWriteM & ~bad;
    misalign_d   = load_w & bad;
    result_src_d = load_w ? ResultSrcM : '0;
    rd_d         = load_w ? RDM : '0;
    pc_plus4_d   = load_w ? PCPlus4M : '0;
    alu_result_d = load_w ? ALUResultM : '0;
    read_data_d  = (load_w & is_load & ~bad) ? load_extend(Funct3M, lane, rd_word) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      misalign_q   <= misalign_d;
    end
  end

  // Write commits only on the completing edge, so a load always sees pre-write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  assign StallM     = stall_c & rst;
  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign RDW        = rd_q;
  assign PCPlus4W   = pc_plus4_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;
  assign MisalignW  = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: three instances (latency 0, 2, 3) against a byte-array model.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, rw_m, mw_m, mr_m, flush, stall_m, rw_w, mis_w;
  logic [2:0][1:0]  rs_m, rs_w;
  logic [2:0][2:0]  f3_m;
  logic [2:0][4:0]  rd_m, rd_w;
  logic [2:0][31:0] pc_m, wd_m, alu_m, pc_w, alu_w, rdat_w;

  mem_stage_lsu #(.MEM_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst[0]), .RegWriteM(rw_m[0]), .MemWriteM(mw_m[0]), .MemReadM(mr_m[0]),
    .ResultSrcM(rs_m[0]), .Funct3M(f3_m[0]), .RDM(rd_m[0]), .PCPlus4M(pc_m[0]),
    .WriteDataM(wd_m[0]), .ALUResultM(alu_m[0]), .FlushW(flush[0]), .StallM(stall_m[0]),
    .RegWriteW(rw_w[0]), .ResultSrcW(rs_w[0]), .RDW(rd_w[0]), .PCPlus4W(pc_w[0]),
    .ALUResultW(alu_w[0]), .ReadDataW(rdat_w[0]), .MisalignW(mis_w[0]));

  mem_stage_lsu #(.MEM_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[1]), .RegWriteM(rw_m[1]), .MemWriteM(mw_m[1]), .MemReadM(mr_m[1]),
    .ResultSrcM(rs_m[1]), .Funct3M(f3_m[1]), .RDM(rd_m[1]), .PCPlus4M(pc_m[1]),
    .WriteDataM(wd_m[1]), .ALUResultM(alu_m[1]), .FlushW(flush[1]), .StallM(stall_m[1]),
    .RegWriteW(rw_w[1]), .ResultSrcW(rs_w[1]), .RDW(rd_w[1]), .PCPlus4W(pc_w[1]),
    .ALUResultW(alu_w[1]), .ReadDataW(rdat_w[1]), .MisalignW(mis_w[1]));

  mem_stage_lsu #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[2]), .RegWriteM(rw_m[2]), .MemWriteM(mw_m[2]), .MemReadM(mr_m[2]),
    .ResultSrcM(rs_m[2]), .Funct3M(f3_m[2]), .RDM(rd_m[2]), .PCPlus4M(pc_m[2]),
    .WriteDataM(wd_m[2]), .ALUResultM(alu_m[2]), .FlushW(flush[2]), .StallM(stall_m[2]),
    .RegWriteW(rw_w[2]), .ResultSrcW(rs_w[2]), .RDW(rd_w[2]), .PCPlus4W(pc_w[2]),
    .ALUResultW(alu_w[2]), .ReadDataW(rdat_w[2]), .MisalignW(mis_w[2]));

  int errors = 0;
  int checks = 0;
  int lat [3] = '{0, 2, 3};

  // Model state: byte-addressed memory, cycles spent waiting, expected W fields.
  logic [7:0]       mb [3][4096];
  int               held [3];
  logic [2:0]       e_rw, e_mis;
  logic [2:0][1:0]  e_rs;
  logic [2:0][4:0]  e_rd;
  logic [2:0][31:0] e_pc, e_alu, e_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic mw, input logic mr, input logic [2:0] f3,
                                input logic [31:0] a);
    if (!mw && !mr) return 1'b0;
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'b00;
      3'd4:    return mw;
      3'd5:    return mw | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit is_acc(input int i);
    return (mw_m[i] | mr_m[i]) && !is_bad(mw_m[i], mr_m[i], f3_m[i], alu_m[i]);
  endfunction

  task automatic bubble(input int i);
    e_rw[i] = 1'b0; e_mis[i] = 1'b0; e_rs[i] = '0; e_rd[i] = '0;
    e_pc[i] = '0;   e_alu[i] = '0;   e_dat[i] = '0;
  endtask

  task automatic model_clear(input int i);
    for (int k = 0; k < 4096; k++) mb[i][k] = 8'h00;
    held[i] = 0;
    bubble(i);
  endtask

  task automatic model_step(input int i);
    int          ba;
    bit          bad;
    logic [31:0] ld;
    logic [15:0] h;
    bad = is_bad(mw_m[i], mr_m[i], f3_m[i], alu_m[i]);
    if (is_acc(i) && lat[i] > 0 && held[i] < lat[i]) begin
      held[i]++;
      bubble(i);
      return;
    end
    held[i] = 0;
    ba = int'(alu_m[i][11:0]);
    ld = 32'h0;
    if (mr_m[i] && !mw_m[i] && !bad) begin
      h = {mb[i][(ba | 1)], mb[i][ba & ~1]};
      case (f3_m[i])
        3'd0: ld = {{24{mb[i][ba][7]}}, mb[i][ba]};
        3'd1: ld = {{16{h[15]}}, h};
        3'd2: ld = {mb[i][ba+3], mb[i][ba+2], mb[i][ba+1], mb[i][ba]};
        3'd4: ld = {24'h0, mb[i][ba]};
        3'd5: ld = {16'h0, h};
        default: ld = 32'h0;
      endcase
    end
    if (mw_m[i] && !bad) begin
      mb[i][ba] = wd_m[i][7:0];
      if (f3_m[i] != 3'd0) mb[i][ba+1] = wd_m[i][15:8];
      if (f3_m[i] == 3'd2) begin
        mb[i][ba+2] = wd_m[i][23:16];
        mb[i][ba+3] = wd_m[i][31:24];
      end
    end
    if (flush[i]) begin
      bubble(i);
    end else begin
      e_rw[i]  = rw_m[i] & ~bad;
      e_mis[i] = bad;
      e_rs[i]  = rs_m[i];
      e_rd[i]  = rd_m[i];
      e_pc[i]  = pc_m[i];
      e_alu[i] = alu_m[i];
      e_dat[i] = ld;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (rst[i]) model_step(i);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d StallM", i), 32'(stall_m[i]),
          32'(rst[i] && is_acc(i) && lat[i] > 0 && held[i] < lat[i]));
      chk($sformatf("d%0d RegWriteW", i), 32'(rw_w[i]), 32'(e_rw[i]));
      chk($sformatf("d%0d MisalignW", i), 32'(mis_w[i]), 32'(e_mis[i]));
      chk($sformatf("d%0d ResultSrcW", i), 32'(rs_w[i]), 32'(e_rs[i]));
      chk($sformatf("d%0d RDW", i), 32'(rd_w[i]), 32'(e_rd[i]));
      chk($sformatf("d%0d PCPlus4W", i), pc_w[i], e_pc[i]);
      chk($sformatf("d%0d ALUResultW", i), alu_w[i], e_alu[i]);
      chk($sformatf("d%0d ReadDataW", i), rdat_w[i], e_dat[i]);
    end
  end

  task automatic set_in(input int i, input logic rw, input logic mw, input logic mr,
                        input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] a);
    rw_m[i] = rw; mw_m[i] = mw; mr_m[i] = mr; rs_m[i] = rs; f3_m[i] = f3;
    rd_m[i] = rd; pc_m[i] = pc4; wd_m[i] = wd; alu_m[i] = a; flush[i] = 1'b0;
  endtask

  // Holds one instruction until it completes; counts cycles with StallM high.
  task automatic issue(input int i, input logic rw, input logic mw, input logic mr,
                       input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] a,
                       input bit fl_end, output int ns);
    int n;
    set_in(i, rw, mw, mr, rs, f3, rd, pc4, wd, a);
    n  = is_acc(i) ? lat[i] + 1 : 1;
    ns = 0;
    for (int k = 0; k < n; k++) begin
      flush[i] = fl_end && (k == n - 1);
      #1;
      if (stall_m[i]) ns++;
      @(posedge clk); #2;
    end
    set_in(i, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic st(input int i, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, output int ns);
    issue(i, 1'b0, 1'b1, 1'b0, 2'd0, f3, 5'd0, 32'h100 + a, wd, a, 1'b0, ns);
  endtask

  task automatic ld(input int i, input logic [2:0] f3, input logic [31:0] a,
                    input logic [4:0] rd, output int ns);
    issue(i, 1'b1, 1'b0, 1'b1, 2'd1, f3, rd, 32'h200 + a, 32'h0, a, 1'b0, ns);
  endtask

  initial begin
    int ns;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst = 3'b111;
    #1 rst = 3'b000;
    for (int i = 0; i < 3; i++) model_clear(i);
    repeat (2) @(posedge clk);
    #2 rst = 3'b111;

    // Single-cycle instance: sizes, extension, misalignment, wrap, pass-through.
    st(0, 3'd2, 32'h10, 32'hDEADBEEF, ns);
    ld(0, 3'd2, 32'h10, 5'd5, ns);
    chk("L0 LW DEADBEEF", rdat_w[0], 32'hDEADBEEF);
    chk("L0 LW rd", 32'(rd_w[0]), 32'd5);
    chk("L0 LW regwrite", 32'(rw_w[0]), 32'd1);
    chk("L0 no stall", 32'(ns), 32'd0);
    st(0, 3'd0, 32'h13, 32'h000000A5, ns);
    ld(0, 3'd0, 32'h13, 5'd6, ns);
    chk("L0 LB sign", rdat_w[0], 32'hFFFFFFA5);
    ld(0, 3'd4, 32'h13, 5'd6, ns);
    chk("L0 LBU zero", rdat_w[0], 32'h000000A5);
    ld(0, 3'd2, 32'h10, 5'd6, ns);
    chk("L0 LW after SB", rdat_w[0], 32'hA5ADBEEF);
    st(0, 3'd1, 32'h12, 32'h00001234, ns);
    ld(0, 3'd5, 32'h12, 5'd8, ns);
    chk("L0 LHU", rdat_w[0], 32'h00001234);
    ld(0, 3'd1, 32'h11, 5'd9, ns);
    chk("L0 LH misalign flag", 32'(mis_w[0]), 32'd1);
    chk("L0 LH misalign regwrite", 32'(rw_w[0]), 32'd0);
    chk("L0 LH misalign data", rdat_w[0], 32'h0);
    st(0, 3'd2, 32'h11, 32'hFFFFFFFF, ns);
    ld(0, 3'd2, 32'h10, 5'd6, ns);
    chk("L0 LW unchanged", rdat_w[0], 32'h1234BEEF);
    st(0, 3'd1, 32'h10, 32'h00008001, ns);
    ld(0, 3'd1, 32'h10, 5'd6, ns);
    chk("L0 LH sign", rdat_w[0], 32'hFFFF8001);
    issue(0, 1'b1, 1'b1, 1'b1, 2'd1, 3'd2, 5'd3, 32'h0, 32'h11223344, 32'h14, 1'b0, ns);
    chk("L0 rd+wr data", rdat_w[0], 32'h0);
    ld(0, 3'd2, 32'h1014, 5'd4, ns);
    chk("L0 LW wrapped", rdat_w[0], 32'h11223344);
    ld(0, 3'd3, 32'h18, 5'd4, ns);
    chk("L0 undefined f3", 32'(mis_w[0]), 32'd1);
    issue(0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0, 5'd7, 32'h104, 32'h0, 32'h12345678, 1'b0, ns);
    chk("L0 alu pass", alu_w[0], 32'h12345678);
    chk("L0 pc4 pass", pc_w[0], 32'h104);
    chk("L0 src pass", 32'(rs_w[0]), 32'd2);

    // Latency 3: stall length and load result.
    st(2, 3'd2, 32'h10, 32'hCAFEF00D, ns);
    chk("L3 store stalls", 32'(ns), 32'd3);
    ld(2, 3'd2, 32'h10, 5'd10, ns);
    chk("L3 load stalls", 32'(ns), 32'd3);
    chk("L3 regwrite", 32'(rw_w[2]), 32'd1);
    chk("L3 data", rdat_w[2], 32'hCAFEF00D);

    // Latency 2: flushed store still commits.
    issue(1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd0, 32'h124, 32'h55, 32'h20, 1'b1, ns);
    chk("L2 flush alu", alu_w[1], 32'h0);
    chk("L2 flush pc4", pc_w[1], 32'h0);
    ld(1, 3'd2, 32'h20, 5'd11, ns);
    chk("L2 LW after flush", rdat_w[1], 32'h00000055);
    chk("L2 load stalls", 32'(ns), 32'd2);

    // Latency 3: reset during the second busy cycle.
    set_in(2, 1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd0, 32'h0, 32'h77, 32'h30);
    repeat (2) begin @(posedge clk); #2; end
    rst[2] = 1'b0;
    model_clear(2);
    #1;
    chk("L3 reset stall", 32'(stall_m[2]), 32'd0);
    chk("L3 reset regwrite", 32'(rw_w[2]), 32'd0);
    @(posedge clk); #2;
    set_in(2, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst[2] = 1'b1;
    ld(2, 3'd2, 32'h30, 5'd12, ns);
    chk("L3 LW after reset", rdat_w[2], 32'h0);
    ld(2, 3'd2, 32'h10, 5'd12, ns);
    chk("L3 mem cleared", rdat_w[2], 32'h0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
